// File: rtl/reg_bank_mp_pkg.sv
// Shared constants, FSM encoding and lane-slice helpers for the multi-port register bank.
package reg_bank_mp_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bank_state_t;

  // LSB of lane `lane` inside a packed bus of `laneW`-bit lanes.
  function automatic int laneLsb(input int lane, input int laneW);
    return lane * laneW;
  endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational read lane: zero-register handling, write bypass and busy flag.
module reg_bank_read_port
  import reg_bank_mp_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = DEF_ADDR_W,
  parameter int WIDTH_DATA_LENGTH = DEF_DATA_W,
  parameter int BYPASS_EN         = 1
) (
  input  logic                         active,
  input  logic [WIDTH_ADDR_LENGTH-1:0] addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] regData,
  input  logic                         pendingBit,
  input  logic                         wen0,
  input  logic [WIDTH_ADDR_LENGTH-1:0] addrD0,
  input  logic [WIDTH_DATA_LENGTH-1:0] dataD0,
  input  logic                         wen1,
  input  logic [WIDTH_ADDR_LENGTH-1:0] addrD1,
  input  logic [WIDTH_DATA_LENGTH-1:0] dataD1,
  output logic [WIDTH_DATA_LENGTH-1:0] data,
  output logic                         busy
);

  logic hit0;
  logic hit1;

  always_comb begin
    hit0 = (BYPASS_EN != 0) && wen0 && (addrD0 == addr);
    hit1 = (BYPASS_EN != 0) && wen1 && (addrD1 == addr);

    data = '0;
    if (active && (addr != '0)) begin
      // Port 1 has write priority, so it also wins the forwarding path.
      if (hit1)
        data = dataD1;
      else if (hit0)
        data = dataD0;
      else
        data = regData;
    end

    busy = active && pendingBit && !(hit0 || hit1);
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: two prioritised write ports, N read lanes, pending-write
// scoreboard and a post-reset clear sequencer that zeroes x1..xN-1 one per cycle.
module reg_bank_mp
  import reg_bank_mp_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = DEF_ADDR_W,
  parameter int WIDTH_DATA_LENGTH = DEF_DATA_W,
  parameter int NUM_REG_BANK      = 1 << WIDTH_ADDR_LENGTH,
  parameter int NUM_READ_PORTS    = 2,
  parameter int BYPASS_EN         = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        WEn0,
  input  logic [WIDTH_ADDR_LENGTH-1:0]                AddrD0,
  input  logic [WIDTH_DATA_LENGTH-1:0]                DataD0,
  input  logic                                        WEn1,
  input  logic [WIDTH_ADDR_LENGTH-1:0]                AddrD1,
  input  logic [WIDTH_DATA_LENGTH-1:0]                DataD1,
  input  logic                                        ResvEn,
  input  logic [WIDTH_ADDR_LENGTH-1:0]                ResvAddr,
  input  logic [NUM_READ_PORTS*WIDTH_ADDR_LENGTH-1:0] AddrR,
  output logic [NUM_READ_PORTS*WIDTH_DATA_LENGTH-1:0] DataR,
  output logic [NUM_READ_PORTS-1:0]                   BusyR,
  output logic                                        Ready
);

  localparam logic [WIDTH_ADDR_LENGTH-1:0] LAST_PTR = WIDTH_ADDR_LENGTH'(NUM_REG_BANK - 1);

  logic [WIDTH_DATA_LENGTH-1:0] regs [NUM_REG_BANK];
  logic [NUM_REG_BANK-1:0]      pending;
  logic [NUM_REG_BANK-1:0]      pendingNext;
  bank_state_t                  state;
  logic [WIDTH_ADDR_LENGTH-1:0] ptr;
  logic                         wen0;
  logic                         wen1;
  logic                         resv;

  // Every operation is masked until the clear sequence has finished.
  assign wen0 = WEn0 & Ready;
  assign wen1 = WEn1 & Ready;
  assign resv = ResvEn & Ready;

  always_comb begin
    pendingNext = pending;
    if (wen0)
      pendingNext[AddrD0] = 1'b0;
    if (wen1)
      pendingNext[AddrD1] = 1'b0;
    // A reservation issued alongside a write to the same register must survive.
    if (resv && (ResvAddr != '0))
      pendingNext[ResvAddr] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= WIDTH_ADDR_LENGTH'(1);
      Ready   <= 1'b0;
      pending <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + WIDTH_ADDR_LENGTH'(1);
      if (ptr == LAST_PTR) begin
        state <= READY;
        Ready <= 1'b1;
      end
    end else begin
      pending <= pendingNext;
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it after rst drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[ptr] <= '0;
      end else begin
        if (wen0 && (AddrD0 != '0))
          regs[AddrD0] <= DataD0;
        if (wen1 && (AddrD1 != '0))
          regs[AddrD1] <= DataD1;
      end
    end
  end

  for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : gRead
    localparam int ALSB = laneLsb(i, WIDTH_ADDR_LENGTH);
    localparam int DLSB = laneLsb(i, WIDTH_DATA_LENGTH);

    logic [WIDTH_ADDR_LENGTH-1:0] laneAddr;
    assign laneAddr = AddrR[ALSB +: WIDTH_ADDR_LENGTH];

    reg_bank_read_port #(
      .WIDTH_ADDR_LENGTH(WIDTH_ADDR_LENGTH),
      .WIDTH_DATA_LENGTH(WIDTH_DATA_LENGTH),
      .BYPASS_EN        (BYPASS_EN)
    ) uPort (
      .active    (Ready),
      .addr      (laneAddr),
      .regData   (regs[laneAddr]),
      .pendingBit(pending[laneAddr]),
      .wen0      (wen0),
      .addrD0    (AddrD0),
      .dataD0    (DataD0),
      .wen1      (wen1),
      .addrD1    (AddrD1),
      .dataD1    (DataD1),
      .data      (DataR[DLSB +: WIDTH_DATA_LENGTH]),
      .busy      (BusyR[i])
    );
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench: a 4-lane bypassing bank (A) and a 2-lane non-bypassing bank (B) share stimulus.
module tb_reg_bank_mp;

  localparam int K_RDY_A  = 0;
  localparam int K_DATA_A = 1;
  localparam int K_BUSY_A = 2;
  localparam int K_DATA_B = 3;
  localparam int K_BUSY_B = 4;
  localparam int K_RDY_B  = 5;

  typedef struct {
    string       tag;
    int          kind;
    int          lane;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        WEn0;
  logic [4:0]  AddrD0;
  logic [31:0] DataD0;
  logic        WEn1;
  logic [4:0]  AddrD1;
  logic [31:0] DataD1;
  logic        ResvEn;
  logic [4:0]  ResvAddr;
  logic [19:0] AddrR4;
  logic [9:0]  AddrR2;
  logic [127:0] DataRA;
  logic [3:0]  BusyRA;
  logic        ReadyA;
  logic [63:0] DataRB;
  logic [1:0]  BusyRB;
  logic        ReadyB;

  assign AddrR2 = AddrR4[9:0];

  always #5 clk = ~clk;

  reg_bank_mp #(.NUM_READ_PORTS(4), .BYPASS_EN(1)) dutA (
    .clk(clk), .rst(rst),
    .WEn0(WEn0), .AddrD0(AddrD0), .DataD0(DataD0),
    .WEn1(WEn1), .AddrD1(AddrD1), .DataD1(DataD1),
    .ResvEn(ResvEn), .ResvAddr(ResvAddr),
    .AddrR(AddrR4), .DataR(DataRA), .BusyR(BusyRA), .Ready(ReadyA)
  );

  reg_bank_mp #(.NUM_READ_PORTS(2), .BYPASS_EN(0)) dutB (
    .clk(clk), .rst(rst),
    .WEn0(WEn0), .AddrD0(AddrD0), .DataD0(DataD0),
    .WEn1(WEn1), .AddrD1(AddrD1), .DataD1(DataD1),
    .ResvEn(ResvEn), .ResvAddr(ResvAddr),
    .AddrR(AddrR2), .DataR(DataRB), .BusyR(BusyRB), .Ready(ReadyB)
  );

  function automatic logic [31:0] observe(input int kind, input int lane);
    case (kind)
      K_RDY_A:  return {31'd0, ReadyA};
      K_DATA_A: return DataRA[lane*32 +: 32];
      K_BUSY_A: return {31'd0, BusyRA[lane]};
      K_DATA_B: return DataRB[lane*32 +: 32];
      K_BUSY_B: return {31'd0, BusyRB[lane]};
      default:  return {31'd0, ReadyB};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int lane, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.kind = kind; x.lane = lane; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = observe(x.kind, x.lane);
      total++;
      assert (obs === x.exp) else begin
        bad++;
        $error("FAIL %s lane%0d: observed %h expected %h", x.tag, x.lane, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WEn0 = 1'b0; WEn1 = 1'b0; ResvEn = 1'b0;
  endtask

  task automatic setLane(input int i, input logic [4:0] a);
    AddrR4[i*5 +: 5] = a;
  endtask

  initial begin
    rst = 1'b1; idle();
    AddrD0 = '0; DataD0 = '0; AddrD1 = '0; DataD1 = '0; ResvAddr = '0; AddrR4 = '0;
    tick(); tick();
    push("rst_ready_A", K_RDY_A, 0, 0);
    push("rst_ready_B", K_RDY_B, 0, 0);
    drain();
    rst = 1'b0;

    for (int e = 1; e <= 31; e++) begin
      tick();
      push("clr_ready_A", K_RDY_A, 0, (e == 31) ? 32'd1 : 32'd0);
      push("clr_ready_B", K_RDY_B, 0, (e == 31) ? 32'd1 : 32'd0);
      drain();
    end

    for (int r = 1; r < 32; r++) begin
      setLane(0, 5'(r));
      push("cleared_A", K_DATA_A, 0, 0);
      push("cleared_B", K_DATA_B, 0, 0);
      drain();
    end

    // Dual write to x5: port 1 wins, forwarded only on A.
    WEn0 = 1; AddrD0 = 5; DataD0 = 32'h11111111;
    WEn1 = 1; AddrD1 = 5; DataD1 = 32'h22222222;
    setLane(0, 5);
    push("dual_byp_A", K_DATA_A, 0, 32'h22222222);
    push("dual_old_B", K_DATA_B, 0, 0);
    drain();
    tick(); idle();
    push("dual_A", K_DATA_A, 0, 32'h22222222);
    push("dual_B", K_DATA_B, 0, 32'h22222222);
    drain();

    WEn0 = 1; AddrD0 = 0; DataD0 = 32'hDEADBEEF; setLane(0, 0);
    push("x0_byp_A", K_DATA_A, 0, 0);
    drain();
    tick(); idle();
    push("x0_A", K_DATA_A, 0, 0);
    push("x0_B", K_DATA_B, 0, 0);
    drain();

    WEn0 = 1; AddrD0 = 7; DataD0 = 32'hCAFEF00D; setLane(0, 7);
    push("byp_A", K_DATA_A, 0, 32'hCAFEF00D);
    push("nobyp_B", K_DATA_B, 0, 0);
    drain();
    tick(); idle();
    push("after_A", K_DATA_A, 0, 32'hCAFEF00D);
    push("after_B", K_DATA_B, 0, 32'hCAFEF00D);
    drain();

    // Scoreboard on x3 and x4 via lane 1.
    ResvEn = 1; ResvAddr = 3; setLane(1, 3);
    push("resv_same_A", K_BUSY_A, 1, 0);
    drain();
    tick(); idle();
    push("resv_A", K_BUSY_A, 1, 1);
    push("resv_B", K_BUSY_B, 1, 1);
    drain();
    WEn1 = 1; AddrD1 = 3; DataD1 = 32'h33;
    push("wr_busy_A", K_BUSY_A, 1, 0);
    push("wr_busy_B", K_BUSY_B, 1, 1);
    push("wr_data_A", K_DATA_A, 1, 32'h33);
    drain();
    tick(); idle();
    push("wr_next_A", K_BUSY_A, 1, 0);
    push("wr_next_B", K_BUSY_B, 1, 0);
    drain();

    ResvEn = 1; ResvAddr = 4; WEn0 = 1; AddrD0 = 4; DataD0 = 32'h44; setLane(1, 4);
    push("setwin_pre_A", K_BUSY_A, 1, 0);
    drain();
    tick(); idle();
    push("setwin_A", K_BUSY_A, 1, 1);
    push("setwin_B", K_BUSY_B, 1, 1);
    push("setwin_dat_B", K_DATA_B, 1, 32'h44);
    drain();
    ResvEn = 1; ResvAddr = 4;
    tick(); idle();
    push("resv_again_A", K_BUSY_A, 1, 1);
    drain();
    ResvEn = 1; ResvAddr = 0; setLane(1, 0);
    tick(); idle();
    push("resv_x0_A", K_BUSY_A, 1, 0);
    push("resv_x0_B", K_BUSY_B, 1, 0);
    drain();

    // Four read lanes.
    WEn0 = 1; AddrD0 = 1; DataD0 = 1; WEn1 = 1; AddrD1 = 2; DataD1 = 2;
    tick();
    AddrD0 = 3; DataD0 = 3; AddrD1 = 4; DataD1 = 4;
    tick(); idle();
    for (int i = 0; i < 4; i++) setLane(i, 5'(i + 1));
    for (int i = 0; i < 4; i++) push("lanes_A", K_DATA_A, i, 32'(i + 1));
    for (int i = 0; i < 2; i++) push("lanes_B", K_DATA_B, i, 32'(i + 1));
    drain();
    for (int i = 0; i < 4; i++) setLane(i, 5'(4 - i));
    for (int i = 0; i < 4; i++) push("lanes_rev_A", K_DATA_A, i, 32'(4 - i));
    drain();

    // Reset in the middle of the clear sequence.
    WEn0 = 1; AddrD0 = 20; DataD0 = 32'h5;
    tick(); idle();
    setLane(0, 20);
    push("x20_A", K_DATA_A, 0, 32'h5);
    drain();
    rst = 1;
    tick();
    rst = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      push("midclr_data_A", K_DATA_A, 0, 0);
      push("midclr_rdy_A", K_RDY_A, 0, 0);
      drain();
    end
    rst = 1;
    tick();
    rst = 0;
    WEn0 = 1; AddrD0 = 20; DataD0 = 32'h77;
    WEn1 = 1; AddrD1 = 21; DataD1 = 32'h88;
    ResvEn = 1; ResvAddr = 9; setLane(1, 9);
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 31) idle();
      push("restart_rdy_A", K_RDY_A, 0, (e == 31) ? 32'd1 : 32'd0);
      push("restart_rdy_B", K_RDY_B, 0, (e == 31) ? 32'd1 : 32'd0);
      if (e < 31) begin
        push("clr_lane_A", K_DATA_A, 0, 0);
        push("clr_busy_A", K_BUSY_A, 1, 0);
      end
      drain();
    end
    push("x20_clr_A", K_DATA_A, 0, 0);
    push("x20_clr_B", K_DATA_B, 0, 0);
    push("x9_busy_A", K_BUSY_A, 1, 0);
    drain();
    setLane(0, 21); setLane(1, 4);
    push("x21_clr_A", K_DATA_A, 0, 0);
    push("x4_busy_A", K_BUSY_A, 1, 0);
    push("x4_busy_B", K_BUSY_B, 1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-port register bank for the RISC-V core, replacing the single-write, two-read bank. Provides NUM_READ_PORTS combinational read ports and two write ports with fixed priority. Adds optional write-to-read bypass, a pending-write scoreboard for hazard detection, and a synchronous-reset clear sequencer. Register 0 is hardwired to zero.

Parameters:
WIDTH_ADDR_LENGTH, 5, register address width
WIDTH_DATA_LENGTH, 32, register data width
NUM_REG_BANK, 1 << WIDTH_ADDR_LENGTH, number of registers
NUM_READ_PORTS, 2, number of read ports (1..4)
BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
WEn0  input  1  write enable, port 0
AddrD0  input  WIDTH_ADDR_LENGTH  write address, port 0
DataD0  input  WIDTH_DATA_LENGTH  write data, port 0
WEn1  input  1  write enable, port 1 (priority port)
AddrD1  input  WIDTH_ADDR_LENGTH  write address, port 1
DataD1  input  WIDTH_DATA_LENGTH  write data, port 1
ResvEn  input  1  reserve destination (mark pending write)
ResvAddr  input  WIDTH_ADDR_LENGTH  register to reserve
AddrR  input  NUM_READ_PORTS*WIDTH_ADDR_LENGTH  packed read addresses, port i at [i*W +: W]
DataR  output  NUM_READ_PORTS*WIDTH_DATA_LENGTH  packed read data
BusyR  output  NUM_READ_PORTS  read port i sources a pending register
Ready  output  1  bank cleared and accepting operations

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- FSM states: CLEAR, READY. Registered clear pointer ptr, width WIDTH_ADDR_LENGTH.
- When rst is sampled high at an edge: state <= CLEAR, ptr <= 1, all scoreboard bits <= 0, Ready <= 0. Register contents are not touched at that edge.
- CLEAR, each edge with rst low: REG[ptr] <= 0, ptr <= ptr+1. On the edge that writes ptr == NUM_REG_BANK-1, state <= READY.
  - Ready therefore rises NUM_REG_BANK-1 edges after the first edge with rst low (31 edges at defaults).
- rst asserted during CLEAR restarts the sequence at ptr=1.
- In CLEAR: WEn0, WEn1 and ResvEn are ignored, every DataR lane reads 0, and BusyR = 0.
- Ready is a registered output equal to (state == READY). Ready = 0 after reset.
- Writes, READY only:
  - Each enabled port writes its data at the edge.
  - Address 0 writes are dropped.
  - If both ports are enabled to the same nonzero address, port 1 data is stored.
- Reads, combinational:
  - DataR lane i = 0 if its address is 0.
  - Otherwise, if BYPASS_EN and WEn1 hits the address, the lane returns DataD1; else if WEn0 hits, DataD0; else REG[addr].
  - With BYPASS_EN = 0, the lane returns REG[addr]. Same-cycle write data becomes visible on the next cycle.
- Scoreboard, one pending bit per register, READY only:
  - An enabled write clears pending[AddrDx].
  - ResvEn sets pending[ResvAddr].
  - Reserve and write to the same address in one cycle: the set wins.
  - ResvAddr 0 is ignored. pending[0] is always 0.
- BusyR[i] = pending[addr_i] AND NOT (BYPASS_EN AND an enabled write port hits addr_i this cycle).
- Reserving an already-pending register leaves it pending. It needs no error or count.

Decomposition:
- Shared package holds:
  - default width, address and register-count constants
  - FSM state encoding: CLEAR, READY
  - read-lane slice helper constants
- One natural sub-module, reg_bank_read_port: a single read lane containing the bypass mux and busy logic. It is instantiated NUM_READ_PORTS times via generate.
- Storage, write arbitration, scoreboard and FSM stay in the top level.

Test Plan:
- Reset then idle: hold rst for 2 cycles, release. Ready = 0 for 30 edges and is 1 after the 31st. Reading x1..x31 then returns 0x00000000.
- Dual write conflict: WEn0 x5=0x11111111, WEn1 x5=0x22222222 in one cycle, then a read of x5 on the next cycle returns 0x22222222. A write of 0xDEADBEEF to x0 is followed by a read of x0 returning 0.
- Bypass: BYPASS_EN=1, WEn0 x7=0xCAFEF00D with AddrR lane0=x7 in the same cycle returns 0xCAFEF00D. With BYPASS_EN=0, the same stimulus returns the old value 0, then 0xCAFEF00D next cycle.
- Scoreboard: ResvEn x3, then a read of x3 gives BusyR=1. Writing x3 gives BusyR=0 that cycle with bypass and 0 next cycle. Simultaneous ResvEn x4 and write x4 leaves x4 pending.
- Reset mid-clear: assert rst 10 edges into CLEAR after writing x20=0x5 earlier. The sequence restarts, Ready rises 31 edges after release, and x20 reads 0. Writes issued during CLEAR are ignored.
- Four read ports (NUM_READ_PORTS=4): write x1..x4 = 1..4, then read all lanes simultaneously. DataR returns 1, 2, 3, 4 in the correct packed lanes.
